grayscaler: RTL and testbench

GRAYSCALER -- requirements
Module: grayscaler

---
 rtl/grayscaler.sv | 155 +++++++++++++++
 tb/tb_grayscaler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grayscaler.sv
// Streams R,G,B bytes from a memory read port, converts each pixel to 8-bit
// luma and hands it downstream with a valid/ready handshake, one frame per enable.
module grayscaler #(
   parameter int N = 450,
   parameter int M = 450
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       gray_enable,
   input  logic [7:0] rwm_data,
   input  logic       rwm_valid,
   output logic       pause,
   output logic [7:0] gray_data,
   output logic       gray_valid,
   input  logic       gray_ready,
   output logic       gray_done
);

   localparam int unsigned PIXELS = N * M;
   localparam int CW = $clog2(PIXELS + 1);
   localparam logic [CW-1:0] LAST_PIX = CW'(PIXELS - 1);

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      COMPUTE,
      OUTPUT,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    byteIdx_q, byteIdx_d;
   logic [CW-1:0] pixCnt_q, pixCnt_d;
   logic [7:0]    r_q, r_d;
   logic [7:0]    g_q, g_d;
   logic [7:0]    b_q, b_d;
   logic [7:0]    grayData_q, grayData_d;
   logic          grayValid_q, grayValid_d;
   logic          pause_q, pause_d;
   logic          grayDone_q, grayDone_d;
   logic [15:0]   weighted;
   logic          abort;

   // Weights sum to 256, so the rounded sum tops out at 65408 and fits 16 bits.
   assign weighted = 16'd77  * {8'h00, r_q}
                   + 16'd150 * {8'h00, g_q}
                   + 16'd29  * {8'h00, b_q}
                   + 16'd128;

   assign abort = !gray_enable &&
                  ((state_q == CAPTURE) || (state_q == COMPUTE) || (state_q == OUTPUT));

   always_comb begin
      state_d     = state_q;
      byteIdx_d   = byteIdx_q;
      pixCnt_d    = pixCnt_q;
      r_d         = r_q;
      g_d         = g_q;
      b_d         = b_q;
      grayData_d  = grayData_q;
      grayValid_d = grayValid_q;
      pause_d     = pause_q;
      grayDone_d  = 1'b0;

      if (abort) begin
         state_d     = IDLE;
         byteIdx_d   = 2'd0;
         pixCnt_d    = '0;
         grayData_d  = 8'h00;
         grayValid_d = 1'b0;
         pause_d     = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gray_enable) begin
                  state_d   = CAPTURE;
                  byteIdx_d = 2'd0;
                  pixCnt_d  = '0;
               end
            end
            CAPTURE: begin
               if (rwm_valid && !pause_q) begin
                  case (byteIdx_q)
                     2'd0:    r_d = rwm_data;
                     2'd1:    g_d = rwm_data;
                     default: b_d = rwm_data;
                  endcase
                  if (byteIdx_q == 2'd2) begin
                     byteIdx_d = 2'd0;
                     state_d   = COMPUTE;
                     pause_d   = 1'b1;
                  end else begin
                     byteIdx_d = byteIdx_q + 2'd1;
                  end
               end
            end
            COMPUTE: begin
               grayData_d  = weighted[15:8];
               grayValid_d = 1'b1;
               state_d     = OUTPUT;
            end
            OUTPUT: begin
               if (gray_ready) begin
                  grayValid_d = 1'b0;
                  pause_d     = 1'b0;
                  pixCnt_d    = pixCnt_q + 1'b1;
                  if (pixCnt_q == LAST_PIX) begin
                     state_d    = DONE;
                     grayDone_d = 1'b1;
                  end else begin
                     state_d = CAPTURE;
                  end
               end
            end
            DONE: begin
               state_d  = IDLE;
               pixCnt_d = '0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         byteIdx_q   <= 2'd0;
         pixCnt_q    <= '0;
         r_q         <= 8'h00;
         g_q         <= 8'h00;
         b_q         <= 8'h00;
         grayData_q  <= 8'h00;
         grayValid_q <= 1'b0;
         pause_q     <= 1'b0;
         grayDone_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         byteIdx_q   <= byteIdx_d;
         pixCnt_q    <= pixCnt_d;
         r_q         <= r_d;
         g_q         <= g_d;
         b_q         <= b_d;
         grayData_q  <= grayData_d;
         grayValid_q <= grayValid_d;
         pause_q     <= pause_d;
         grayDone_q  <= grayDone_d;
      end
   end

   assign pause      = pause_q;
   assign gray_data  = grayData_q;
   assign gray_valid = grayValid_q;
   assign gray_done  = grayDone_q;

endmodule

// File: tb/tb_grayscaler.sv
// Bench for grayscaler: a 2-pixel-frame instance driven from a vector table with a
// scoreboard of expected luma values, plus a 1-pixel-frame instance for the done pulse.
module tb_grayscaler;

   logic       clk = 1'b0;
   logic       rst;
   logic       gray_enable;
   logic [7:0] rwm_data;
   logic       rwm_valid;
   logic       gray_ready;

   logic       pause, gray_valid, gray_done;
   logic [7:0] gray_data;
   logic       onePause, oneValid, oneDone;
   logic [7:0] oneData;

   int total = 0;
   int bad = 0;
   int hsCount = 0;
   int doneCount = 0;
   int framesDone = 0;
   int hsAtStart = 0;
   logic [7:0] expQ[$];

   typedef struct {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      int         gap;
      logic [7:0] expGray;
   } vec_t;
   vec_t vecs[10];

   grayscaler #(.N(2), .M(1)) dut (
      .clk(clk), .rst(rst), .gray_enable(gray_enable),
      .rwm_data(rwm_data), .rwm_valid(rwm_valid), .pause(pause),
      .gray_data(gray_data), .gray_valid(gray_valid),
      .gray_ready(gray_ready), .gray_done(gray_done)
   );

   grayscaler #(.N(1), .M(1)) dutOne (
      .clk(clk), .rst(rst), .gray_enable(gray_enable),
      .rwm_data(rwm_data), .rwm_valid(rwm_valid), .pause(onePause),
      .gray_data(oneData), .gray_valid(oneValid),
      .gray_ready(gray_ready), .gray_done(oneDone)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Handshakes complete on the next rising edge; score them mid-cycle.
   always @(negedge clk) begin
      if (gray_done) doneCount++;
      if (!rst && gray_enable && gray_valid && gray_ready) begin
         hsCount++;
         if (expQ.size() == 0) checkOutput("sb_underflow", 1, 0);
         else checkOutput("sb_gray", int'(gray_data), int'(expQ.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] v);
      rwm_valid = 1'b1;
      rwm_data  = v;
      tick();
      rwm_valid = 1'b0;
   endtask

   task automatic waitNoPause();
      int n = 0;
      while (pause && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) checkOutput("pause_timeout", 1, 0);
   endtask

   task automatic sendPixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input int gap, input logic [7:0] expGray);
      waitNoPause();
      applyStimulus(r);
      applyStimulus(g);
      for (int k = 0; k < gap; k++) begin
         rwm_data = 8'hEE;
         tick();
         checkOutput("gap_pause", int'(pause), 0);
      end
      expQ.push_back(expGray);
      applyStimulus(b);
   endtask

   task automatic startFrame();
      gray_enable = 1'b1;
      hsAtStart = hsCount;
      tick();
   endtask

   task automatic endFrame();
      int n = 0;
      while (!gray_done && n < 20) begin
         tick();
         n++;
      end
      checkOutput("done_seen", int'(gray_done), 1);
      checkOutput("frame_handshakes", hsCount - hsAtStart, 2);
      framesDone++;
      tick();
      checkOutput("done_width", int'(gray_done), 0);
      gray_enable = 1'b0;
   endtask

   initial begin
      vecs[0] = '{8'hFF, 8'hFF, 8'hFF, 0, 8'd255};
      vecs[1] = '{8'hFF, 8'h00, 8'h00, 0, 8'd77};
      vecs[2] = '{8'h00, 8'hFF, 8'h00, 0, 8'd149};
      vecs[3] = '{8'h00, 8'h00, 8'hFF, 0, 8'd29};
      vecs[4] = '{8'h10, 8'h20, 8'h30, 0, 8'd29};
      vecs[5] = '{8'h10, 8'h20, 8'h30, 4, 8'd29};
      vecs[6] = '{8'hC8, 8'h64, 8'h32, 0, 8'd124};
      vecs[7] = '{8'h12, 8'h34, 8'h56, 0, 8'd46};
      vecs[8] = '{8'h80, 8'h80, 8'h80, 0, 8'd128};
      vecs[9] = '{8'h01, 8'h02, 8'h03, 0, 8'd2};

      rst = 1'b1;
      gray_enable = 1'b1;
      rwm_valid = 1'b1;
      rwm_data = 8'h5A;
      gray_ready = 1'b1;
      repeat (3) tick();
      checkOutput("rst_data", int'(gray_data), 0);
      checkOutput("rst_valid", int'(gray_valid), 0);
      checkOutput("rst_pause", int'(pause), 0);
      checkOutput("rst_done", int'(gray_done), 0);
      rwm_valid = 1'b0;
      gray_enable = 1'b0;
      rst = 1'b0;
      tick();

      // White pixel through both instances, with cycle-exact latency checks.
      startFrame();
      applyStimulus(8'hFF);
      applyStimulus(8'hFF);
      expQ.push_back(8'hFF);
      applyStimulus(8'hFF);
      checkOutput("lat_pause_e0", int'(pause), 1);
      checkOutput("lat_one_pause_e0", int'(onePause), 1);
      checkOutput("lat_valid_e0", int'(gray_valid), 0);
      tick();
      checkOutput("lat_valid_e1", int'(gray_valid), 1);
      checkOutput("lat_data_e1", int'(gray_data), 255);
      checkOutput("one_valid_e1", int'(oneValid), 1);
      checkOutput("one_data_e1", int'(oneData), 255);
      checkOutput("one_done_e1", int'(oneDone), 0);
      tick();
      checkOutput("one_done_e2", int'(oneDone), 1);
      checkOutput("lat_valid_e2", int'(gray_valid), 0);
      checkOutput("lat_pause_e2", int'(pause), 0);
      checkOutput("early_done", int'(gray_done), 0);
      tick();
      checkOutput("one_done_e3", int'(oneDone), 0);
      sendPixel(8'h01, 8'h02, 8'h03, 0, 8'd2);
      endFrame();
      tick();

      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) startFrame();
         sendPixel(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].gap, vecs[i].expGray);
         if (i % 2 == 1) begin
            endFrame();
            tick();
         end
      end

      // Downstream stalls for 6 cycles while memory keeps offering bytes.
      startFrame();
      gray_ready = 1'b0;
      sendPixel(8'hC8, 8'h64, 8'h32, 0, 8'd124);
      tick();
      checkOutput("stall_valid_rise", int'(gray_valid), 1);
      for (int k = 0; k < 6; k++) begin
         rwm_valid = 1'b1;
         rwm_data = 8'hAA;
         tick();
         checkOutput("stall_valid", int'(gray_valid), 1);
         checkOutput("stall_data", int'(gray_data), 124);
         checkOutput("stall_pause", int'(pause), 1);
      end
      rwm_valid = 1'b0;
      gray_ready = 1'b1;
      tick();
      checkOutput("stall_release", int'(gray_valid), 0);
      sendPixel(8'h00, 8'h00, 8'h00, 0, 8'd0);
      endFrame();
      tick();

      // Reset in the middle of a pixel, after the G byte.
      startFrame();
      applyStimulus(8'hFF);
      applyStimulus(8'hFF);
      rst = 1'b1;
      gray_enable = 1'b0;
      tick();
      checkOutput("rstmid_valid", int'(gray_valid), 0);
      checkOutput("rstmid_pause", int'(pause), 0);
      checkOutput("rstmid_done", int'(gray_done), 0);
      checkOutput("rstmid_data", int'(gray_data), 0);
      rst = 1'b0;
      tick();
      startFrame();
      sendPixel(8'h00, 8'hFF, 8'h00, 0, 8'd149);
      sendPixel(8'h80, 8'h80, 8'h80, 0, 8'd128);
      endFrame();
      tick();

      // Enable dropped in the middle of a pixel, after the G byte.
      startFrame();
      applyStimulus(8'hFF);
      applyStimulus(8'hFF);
      gray_enable = 1'b0;
      tick();
      checkOutput("abort_valid", int'(gray_valid), 0);
      checkOutput("abort_pause", int'(pause), 0);
      checkOutput("abort_done", int'(gray_done), 0);
      checkOutput("abort_data", int'(gray_data), 0);
      tick();
      startFrame();
      sendPixel(8'h00, 8'h00, 8'hFF, 0, 8'd29);
      sendPixel(8'hFF, 8'h00, 8'h00, 0, 8'd77);
      endFrame();
      repeat (3) tick();

      checkOutput("sb_leftover", expQ.size(), 0);
      checkOutput("done_pulses", doneCount, framesDone);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
